// File: rtl/core_pkg.sv
// Shared pipeline types for the core: pipeline bus payload, memory-op encodings
// and the memory-access stage state encoding.
package core;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DMEM_BE_W = 4;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    // Plain vector type with named constants keeps the encoding stable for legacy users
    typedef logic [1:0] mem_state_t;
    localparam mem_state_t IDLE = 2'd0;
    localparam mem_state_t REQ  = 2'd1;
    localparam mem_state_t RESP = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0]    pc;
        logic [REG_IDX_W-1:0] rd_addr;
        logic                 rf_wr_en;
        mem_op_t              mem_op;
        logic [WORD_W-1:0]    rs2_data;
        logic [WORD_W-1:0]    rd_res;
    } pipeline_bus_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory: byte enables, store replication,
// load right-alignment and misalignment detection. Purely combinational.
module mem_lane_align
    import core::*;
(
    input  mem_op_t              mem_op,
    input  logic [1:0]           addr_lo,
    input  logic [WORD_W-1:0]    store_data,
    input  logic [1:0]           load_addr_lo,
    input  logic [WORD_W-1:0]    load_data,
    output logic [DMEM_BE_W-1:0] be_c,
    output logic [WORD_W-1:0]    wdata_c,
    output logic [WORD_W-1:0]    load_c,
    output logic                 misalign_c,
    output logic                 is_mem_c,
    output logic                 is_store_c
);

    localparam logic [DMEM_BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [DMEM_BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [DMEM_BE_W-1:0] BE_WORD = 4'b1111;

    // Decode the op into lane enables, write replication and alignment check
    always_comb begin
        be_c       = '0;
        wdata_c    = '0;
        misalign_c = 1'b0;
        is_mem_c   = 1'b1;
        is_store_c = 1'b0;
        case (mem_op)
            MEM_LB, MEM_LBU: begin
                be_c = BE_BYTE << addr_lo;
            end
            MEM_LH, MEM_LHU: begin
                be_c       = BE_HALF << addr_lo;
                misalign_c = addr_lo[0];
            end
            MEM_LW: begin
                be_c       = BE_WORD;
                misalign_c = |addr_lo;
            end
            MEM_SB: begin
                be_c       = BE_BYTE << addr_lo;
                wdata_c    = {4{store_data[7:0]}};
                is_store_c = 1'b1;
            end
            MEM_SH: begin
                be_c       = BE_HALF << addr_lo;
                wdata_c    = {2{store_data[15:0]}};
                misalign_c = addr_lo[0];
                is_store_c = 1'b1;
            end
            MEM_SW: begin
                be_c       = BE_WORD;
                wdata_c    = store_data;
                misalign_c = |addr_lo;
                is_store_c = 1'b1;
            end
            default: begin
                is_mem_c = 1'b0;
            end
        endcase
    end

    // Load data is right-aligned and zero-filled; sign extension happens downstream
    always_comb begin
        load_c = load_data >> {load_addr_lo, 3'b000};
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: captures the EX result, issues one data-memory
// request per load/store and hands a registered result to sign extension.
module mem_access
    import core::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  pipeline_bus_t        bus_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output pipeline_bus_t        bus_o,
    output logic                 valid_o,
    output logic                 misalign_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [ADDR_W-1:0]    dmem_addr_o,
    output logic [DMEM_BE_W-1:0] dmem_be_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i
);

    mem_state_t          state_q;
    mem_state_t          state_d;
    pipeline_bus_t       hold_q;
    pipeline_bus_t       hold_d;
    pipeline_bus_t       bus_d;
    logic                valid_d;
    logic                misalign_d;
    logic                ready_d;
    logic                req_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DMEM_BE_W-1:0] be_d;
    logic [XLEN-1:0]     wdata_d;

    logic [DMEM_BE_W-1:0] lane_be;
    logic [WORD_W-1:0]   lane_wdata;
    logic [WORD_W-1:0]   lane_load;
    logic                lane_misalign;
    logic                lane_is_mem;
    logic                lane_is_store;

    // Issue-side lanes come from the incoming bus; load shift uses the held address
    mem_lane_align u_lane (
        .mem_op       (bus_i.mem_op),
        .addr_lo      (bus_i.rd_res[1:0]),
        .store_data   (bus_i.rs2_data),
        .load_addr_lo (hold_q.rd_res[1:0]),
        .load_data    (WORD_W'(dmem_rdata_i)),
        .be_c         (lane_be),
        .wdata_c      (lane_wdata),
        .load_c       (lane_load),
        .misalign_c   (lane_misalign),
        .is_mem_c     (lane_is_mem),
        .is_store_c   (lane_is_store)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        bus_d      = bus_o;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        req_d      = dmem_req_o;
        we_d       = dmem_we_o;
        addr_d     = dmem_addr_o;
        be_d       = dmem_be_o;
        wdata_d    = dmem_wdata_o;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    hold_d = bus_i;
                    if (!lane_is_mem) begin
                        valid_d = 1'b1;
                        bus_d   = bus_i;
                    end else if (lane_misalign) begin
                        valid_d         = 1'b1;
                        misalign_d      = 1'b1;
                        bus_d           = bus_i;
                        bus_d.mem_op    = MEM_NOP;
                        bus_d.rf_wr_en  = 1'b0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = lane_is_store;
                        addr_d  = ADDR_W'({bus_i.rd_res[WORD_W-1:2], 2'b00});
                        be_d    = lane_be;
                        wdata_d = XLEN'(lane_wdata);
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    req_d = 1'b0;
                    if (dmem_we_o) begin
                        state_d        = IDLE;
                        valid_d        = 1'b1;
                        bus_d          = hold_q;
                        bus_d.rf_wr_en = 1'b0;
                        bus_d.rd_res   = hold_q.rs2_data;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    state_d      = IDLE;
                    valid_d      = 1'b1;
                    bus_d        = hold_q;
                    bus_d.rd_res = lane_load;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            bus_o        <= '0;
            valid_o      <= 1'b0;
            misalign_o   <= 1'b0;
            ready_o      <= 1'b1;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            bus_o        <= bus_d;
            valid_o      <= valid_d;
            misalign_o   <= misalign_d;
            ready_o      <= ready_d;
            dmem_req_o   <= req_d;
            dmem_we_o    <= we_d;
            dmem_addr_o  <= addr_d;
            dmem_be_o    <= be_d;
            dmem_wdata_o <= wdata_d;
        end
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ADDR_W, default 32, data-memory address width.
REQ-002 Parameter XLEN, default 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bus_i  input  core::pipeline_bus_t  EX result: rd_res is the effective address, rs2_data is the store data, mem_op is the memory operation.
REQ-006 valid_i  input  1  bus_i holds an instruction.
REQ-007 ready_o  output  1  stage can accept bus_i this cycle.
REQ-008 bus_o  output  core::pipeline_bus_t  registered result to the sign-extension stage.
REQ-009 valid_o  output  1  bus_o is valid; one-cycle pulse per instruction.
REQ-010 misalign_o  output  1  misaligned access flag, asserted together with valid_o.
REQ-011 dmem_req_o  output  1  memory request.
REQ-012 dmem_we_o  output  1  1 = store.
REQ-013 dmem_addr_o  output  ADDR_W  word-aligned address (addr[1:0] = 0).
REQ-014 dmem_be_o  output  4  byte enables.
REQ-015 dmem_wdata_o  output  XLEN  lane-replicated store data.
REQ-016 dmem_gnt_i  input  1  request accepted.
REQ-017 dmem_rvalid_i  input  1  read data valid.
REQ-018 dmem_rdata_i  input  XLEN  read word.

Function
REQ-019 The FSM SHALL have states IDLE, REQ and RESP; ready_o SHALL be 1 only in IDLE.
REQ-020 A handshake (valid_i && ready_o) SHALL capture bus_i into an internal holding register.
REQ-021 A captured non-memory op (MEM_NOP) SHALL be presented on bus_o with valid_o the next cycle, unchanged, and the FSM SHALL stay in IDLE (1-cycle latency).
REQ-022 A captured aligned memory op SHALL move the FSM IDLE->REQ; dmem_req_o SHALL be 1 in REQ only, and address, we, be and wdata SHALL be held stable until gnt.
REQ-023 In REQ with dmem_gnt_i, a store SHALL go REQ->IDLE and emit valid_o the next cycle, with rf_wr_en=0 and rd_res = raw rs2_data.
REQ-024 In REQ with dmem_gnt_i, a load SHALL go REQ->RESP.
REQ-025 In RESP with dmem_rvalid_i, the FSM SHALL go RESP->IDLE and emit valid_o the next cycle; rd_res SHALL be dmem_rdata_i shifted right by 8*addr[1:0], zero-filled (sign extension is downstream).
REQ-026 dmem_rvalid_i SHALL be ignored outside RESP; the memory guarantees rvalid arrives at least one cycle after gnt.
REQ-027 Store lanes: SB be=0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=0011<<addr[1:0], wdata={2{data[15:0]}}; SW be=1111, wdata=data.
REQ-028 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-029 A misaligned op SHALL issue no request, and SHALL emit valid_o and misalign_o the next cycle with mem_op=MEM_NOP and rf_wr_en=0.
REQ-030 All bus_o fields other than rd_res, rf_wr_en and mem_op SHALL pass through from the captured bus_i.
REQ-031 valid_o SHALL be 0 in every cycle that does not complete an instruction, including while waiting in REQ or RESP.
REQ-032 A new instruction SHALL be accepted in the same cycle valid_o pulses for the previous one if the FSM is in IDLE.

Reset
REQ-033 Asserting rst_n low SHALL force state=IDLE and clear valid_o, misalign_o, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o and all of bus_o to 0, immediately and asynchronously.
REQ-034 A reset taken in REQ or RESP SHALL abandon the access; a late rvalid after reset release SHALL be ignored.

Structure
REQ-035 mem_state_t (IDLE/REQ/RESP) and DMEM_BE_W=4 SHALL be added to package core, beside the existing mem_op encodings.
REQ-036 Lane steering (be/wdata generation, load shift, misalign check) SHALL be a combinational sub-module mem_lane_align.

Verification
REQ-037 ADD with rd_res=0x1234 -> valid_o next cycle, bus_o.rd_res=0x1234, no dmem_req_o.
REQ-038 SB addr=0x103, rs2_data=0xAB, gnt after 2 cycles -> be=1000, wdata=0xABABABAB, addr=0x100, valid_o after gnt, rf_wr_en=0.
REQ-039 LHU addr=0x202, rdata=0xBEEF1234, rvalid 3 cycles after gnt -> rd_res=0x0000BEEF, ready_o=0 until completion.
REQ-040 LW addr=0x301 -> no dmem_req_o, valid_o and misalign_o next cycle, mem_op=MEM_NOP.
REQ-041 rst_n low while in RESP, then rvalid after release -> outputs 0, state IDLE, valid_o stays 0.
REQ-042 Back-to-back ADD, LW, ADD with zero-wait memory -> three valid_o pulses in order, correct rd_res on each.
